// File: rtl/ex_issue_stage.sv
// EX issue stage: decodes MIPS ALU/compare ops into ALU controls and holds them
// in a two-entry in-order buffer (head + skid) toward the ALU.
module ex_issue_stage #(
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  dst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        AddSel,
  output logic        ArithSel,
  output logic        sign,
  output logic [2:0]  ALUSel,
  output logic [2:0]  CompSel,
  output logic [4:0]  out_dst,
  output logic        illegal
);

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_OR  = 3'b001, ALU_AND = 3'b010,
                         ALU_XOR = 3'b011, ALU_SLL = 3'b100, ALU_SRL = 3'b101,
                         ALU_CMP = 3'b110;
  localparam logic [2:0] CMP_LT = 3'b010, CMP_EQ = 3'b100, CMP_NE = 3'b101;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        addsel;
    logic        arithsel;
    logic        sign;
    logic [2:0]  alusel;
    logic [2:0]  compsel;
    logic        illegal;
    logic [4:0]  dst;
  } ent_t;

  ent_t        dec, head_q, skid_q, head_d, skid_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        legal, acc, ret;
  logic [31:0] sext, zext, rr_b;

  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'b0, imm};
  assign rr_b = rt_val;

  // Decode: every control starts at zero so unused fields stay zero per op.
  always_comb begin
    dec     = '0;
    dec.dst = dst;
    legal   = 1'b1;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20: begin dec.a = rs_val; dec.b = rr_b; dec.sign = 1'b1; end
        6'h21: begin dec.a = rs_val; dec.b = rr_b; end
        6'h22: begin dec.a = rs_val; dec.b = rr_b; dec.addsel = 1'b1; dec.sign = 1'b1; end
        6'h23: begin dec.a = rs_val; dec.b = rr_b; dec.addsel = 1'b1; end
        6'h24: begin dec.a = rs_val; dec.b = rr_b; dec.alusel = ALU_AND; end
        6'h25: begin dec.a = rs_val; dec.b = rr_b; dec.alusel = ALU_OR;  end
        6'h26: begin dec.a = rs_val; dec.b = rr_b; dec.alusel = ALU_XOR; end
        6'h00: begin dec.a = rt_val; dec.b = {27'b0, shamt}; dec.alusel = ALU_SLL; end
        6'h02: begin dec.a = rt_val; dec.b = {27'b0, shamt}; dec.alusel = ALU_SRL; end
        6'h03: begin
          dec.a = rt_val; dec.b = {27'b0, shamt}; dec.alusel = ALU_SRL; dec.arithsel = 1'b1;
        end
        6'h04: begin dec.a = rt_val; dec.b = {27'b0, rs_val[4:0]}; dec.alusel = ALU_SLL; end
        6'h06: begin dec.a = rt_val; dec.b = {27'b0, rs_val[4:0]}; dec.alusel = ALU_SRL; end
        6'h07: begin
          dec.a = rt_val; dec.b = {27'b0, rs_val[4:0]}; dec.alusel = ALU_SRL; dec.arithsel = 1'b1;
        end
        6'h2A: begin
          dec.a = rs_val; dec.b = rr_b; dec.alusel = ALU_CMP; dec.compsel = CMP_LT; dec.sign = 1'b1;
        end
        6'h2B: begin dec.a = rs_val; dec.b = rr_b; dec.alusel = ALU_CMP; dec.compsel = CMP_LT; end
        default: legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08: begin dec.a = rs_val; dec.b = sext; dec.sign = 1'b1; end
        6'h09: begin dec.a = rs_val; dec.b = sext; end
        6'h0A: begin
          dec.a = rs_val; dec.b = sext; dec.alusel = ALU_CMP; dec.compsel = CMP_LT; dec.sign = 1'b1;
        end
        6'h0B: begin dec.a = rs_val; dec.b = sext; dec.alusel = ALU_CMP; dec.compsel = CMP_LT; end
        6'h0C: begin dec.a = rs_val; dec.b = zext; dec.alusel = ALU_AND; end
        6'h0D: begin dec.a = rs_val; dec.b = zext; dec.alusel = ALU_OR;  end
        6'h0E: begin dec.a = rs_val; dec.b = zext; dec.alusel = ALU_XOR; end
        6'h04: begin dec.a = rs_val; dec.b = rr_b; dec.alusel = ALU_CMP; dec.compsel = CMP_EQ; end
        6'h05: begin dec.a = rs_val; dec.b = rr_b; dec.alusel = ALU_CMP; dec.compsel = CMP_NE; end
        default: legal = 1'b0;
      endcase
    end
    // Undecodable ops become an OR of zeros; only the flag depends on the mode.
    if (!legal) begin
      dec         = '0;
      dec.dst     = dst;
      dec.alusel  = ALU_OR;
      dec.illegal = !ILLEGAL_AS_NOP;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign acc       = in_valid && in_ready && !flush;
  assign ret       = out_valid && out_ready && !flush;

  // Occupancy / entry movement; flush dominates accept and retire.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (acc && ret) begin
      if (cnt_q == 2'd1) head_d = dec;
    end else if (ret) begin
      head_d = skid_q;
      cnt_d  = cnt_q - 2'd1;
    end else if (acc) begin
      if (cnt_q == 2'd0) head_d = dec;
      else               skid_d = dec;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      head_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      in_ready <= (cnt_d != 2'd2);
    end
  end

  assign a        = head_q.a;
  assign b        = head_q.b;
  assign AddSel   = head_q.addsel;
  assign ArithSel = head_q.arithsel;
  assign sign     = head_q.sign;
  assign ALUSel   = head_q.alusel;
  assign CompSel  = head_q.compsel;
  assign illegal  = head_q.illegal;
  assign out_dst  = head_q.dst;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Randomized + directed bench for ex_issue_stage against a queue-based model.
module tb_ex_issue_stage;
  logic        clk = 1'b0, rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, dst, out_dst;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, a, b;
  logic        AddSel, ArithSel, sign, illegal;
  logic [2:0]  ALUSel, CompSel;

  always #5 clk = ~clk;

  ex_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm(imm),
    .rs_val(rs_val), .rt_val(rt_val), .dst(dst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
    .AddSel(AddSel), .ArithSel(ArithSel), .sign(sign), .ALUSel(ALUSel),
    .CompSel(CompSel), .out_dst(out_dst), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        addsel;
    logic        arithsel;
    logic        sign;
    logic [2:0]  alusel;
    logic [2:0]  compsel;
    logic        illegal;
    logic [4:0]  dst;
  } exp_t;

  int errs = 0, checks = 0;
  exp_t       q[$];
  logic [4:0] log_q[$];
  bit         exp_rdy, m_acc;

  // Behavioural decode straight from the op table.
  function automatic exp_t model(logic [5:0] op, logic [5:0] fn, logic [4:0] sh,
                                 logic [15:0] im, logic [31:0] rs, logic [31:0] rt,
                                 logic [4:0] d);
    exp_t e;
    bit ok = 1;
    logic [31:0] se = {{16{im[15]}}, im};
    logic [31:0] ze = {16'h0, im};
    e = '0;
    e.dst = d;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21, 6'h22, 6'h23: begin
          e.a = rs; e.b = rt; e.addsel = fn[1]; e.sign = !fn[0];
        end
        6'h24: begin e.a = rs; e.b = rt; e.alusel = 3'd2; end
        6'h25: begin e.a = rs; e.b = rt; e.alusel = 3'd1; end
        6'h26: begin e.a = rs; e.b = rt; e.alusel = 3'd3; end
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
          e.a = rt;
          e.b = fn[2] ? 32'(rs % 32) : 32'(sh);
          e.alusel = fn[1] ? 3'd5 : 3'd4;
          e.arithsel = (fn[1:0] == 2'b11);
        end
        6'h2A, 6'h2B: begin
          e.a = rs; e.b = rt; e.alusel = 3'd6; e.compsel = 3'd2; e.sign = !fn[0];
        end
        default: ok = 0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin e.a = rs; e.b = se; e.sign = !op[0]; end
        6'h0A, 6'h0B: begin e.a = rs; e.b = se; e.alusel = 3'd6; e.compsel = 3'd2; e.sign = !op[0]; end
        6'h0C: begin e.a = rs; e.b = ze; e.alusel = 3'd2; end
        6'h0D: begin e.a = rs; e.b = ze; e.alusel = 3'd1; end
        6'h0E: begin e.a = rs; e.b = ze; e.alusel = 3'd3; end
        6'h04, 6'h05: begin e.a = rs; e.b = rt; e.alusel = 3'd6; e.compsel = op[0] ? 3'd5 : 3'd4; end
        default: ok = 0;
      endcase
    end
    if (!ok) begin
      e = '0; e.dst = d; e.alusel = 3'd1; e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Reference: in-order queue of depth 2 with a registered ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_rdy = 1'b0;
    end else begin
      if (flush) q.delete();
      else begin
        m_acc = in_valid && exp_rdy;
        if (q.size() > 0 && out_ready) begin
          log_q.push_back(q[0].dst);
          void'(q.pop_front());
        end
        if (m_acc) q.push_back(model(opcode, funct, shamt, imm, rs_val, rt_val, dst));
      end
      exp_rdy = (q.size() != 2);
    end
  end

  // Cycle compare.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t act;
      act = {a, b, AddSel, ArithSel, sign, ALUSel, CompSel, illegal, out_dst};
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== exp_rdy ||
          (q.size() != 0 && act !== q[0])) begin
        errs++;
        $display("FAIL cycle t=%0t vld=%b rdy=%b got=%h want vld=%b rdy=%b %h", $time,
                 out_valid, in_ready, act, q.size() != 0, exp_rdy,
                 (q.size() != 0) ? q[0] : exp_t'(0));
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic set_in(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] sh,
                        logic [15:0] im, logic [31:0] rs, logic [31:0] rt, logic [4:0] d);
    in_valid = v; opcode = op; funct = fn; shamt = sh; imm = im;
    rs_val = rs; rt_val = rt; dst = d;
  endtask

  // Present one instruction for one cycle; on return it is the head.
  task automatic issue1(logic [5:0] op, logic [5:0] fn, logic [4:0] sh, logic [15:0] im,
                        logic [31:0] rs, logic [31:0] rt, logic [4:0] d);
    @(negedge clk);
    out_ready = 1'b1; flush = 1'b0;
    set_in(1'b1, op, fn, sh, im, rs, rt, d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [5:0] ops[10] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h3F};
  logic [5:0] fns[15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00,
                          6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h2A, 6'h2B};

  initial begin
    exp_t m;
    bit   got;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, '0, '0, '0, '0, '0, '0, '0);

    // Model pins.
    m = model(6'h08, 6'h00, 5'd0, 16'hFF80, 32'd1, 32'd0, 5'd1);
    chk("model_addi_sext", m.b, 32'hFFFFFF80);
    m = model(6'h00, 6'h07, 5'd0, 16'h0, 32'h45, 32'h1234, 5'd1);
    chk("model_srav", {m.b[7:0], 7'd0, m.arithsel, 13'd0, m.alusel}, {8'h05, 7'd0, 1'b1, 13'd0, 3'd5});

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ab", a | b, 0);
    chk("rst_ctl", {AddSel, ArithSel, sign, ALUSel, CompSel, illegal, out_dst}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    issue1(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd3, 5'd9);
    chk("add_vld", 32'(out_valid), 1);
    chk("add_a", a, 5);
    chk("add_b", b, 3);
    chk("add_ctl", {ALUSel, AddSel, sign}, {3'b000, 1'b0, 1'b1});

    issue1(6'h00, 6'h03, 5'd17, 16'h0, 32'h0, 32'h80000000, 5'd10);
    chk("sra_a", a, 32'h80000000);
    chk("sra_b", b, 32'h11);
    chk("sra_ctl", {ALUSel, ArithSel}, {3'b101, 1'b1});

    issue1(6'h00, 6'h06, 5'd0, 16'h0, 32'h23, 32'h77, 5'd11);
    chk("srlv_b", b, 3);
    chk("srlv_arith", 32'(ArithSel), 0);

    issue1(6'h0B, 6'h00, 5'd0, 16'hFFFF, 32'h1, 32'h0, 5'd12);
    chk("sltiu_b", b, 32'hFFFFFFFF);
    chk("sltiu_ctl", {ALUSel, CompSel, sign}, {3'b110, 3'b010, 1'b0});

    issue1(6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'h1, 32'h0, 5'd13);
    chk("ori_b", b, 32'h0000FFFF);

    issue1(6'h3F, 6'h00, 5'd0, 16'h1234, 32'hDEAD, 32'hBEEF, 5'd14);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_alusel", 32'(ALUSel), 1);
    chk("ill_ab", a | b, 0);

    // Backpressure: three back-to-back with out_ready=0.
    @(negedge clk);
    log_q.delete();
    out_ready = 1'b0;
    set_in(1'b1, 6'h00, 6'h21, 5'd0, 16'h0, 32'd1, 32'd1, 5'd1);
    @(negedge clk); dst = 5'd2; rs_val = 32'd2;
    @(negedge clk); dst = 5'd3; rs_val = 32'd3;
    chk("bp_in_ready0", 32'(in_ready), 0);
    repeat (3) @(negedge clk);
    chk("bp_hold_dst", 32'(out_dst), 1);
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    chk("bp_accept_third", 32'(got), 1);
    repeat (4) @(negedge clk);
    chk("bp_order", {log_q.size() == 3 ? {log_q[0], log_q[1], log_q[2]} : 15'h7FFF},
        {5'd1, 5'd2, 5'd3});

    // Flush with two buffered and one presented.
    log_q.delete();
    out_ready = 1'b0;
    set_in(1'b1, 6'h00, 6'h25, 5'd0, 16'h0, 32'd4, 32'd4, 5'd4);
    @(negedge clk); dst = 5'd5;
    @(negedge clk); dst = 5'd6; flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld", 32'(out_valid), 0);
    chk("flush_rdy", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("flush_nothing_issued", log_q.size(), 0);

    // Async reset while stalled.
    out_ready = 1'b0;
    set_in(1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd7, 32'd7, 5'd7);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 0);
    chk("arst_ab", a | b, 0);
    chk("arst_rdy", 32'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 9);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      if (r < 5)      begin opcode = 6'h00; funct = fns[$urandom_range(0, 14)]; end
      else if (r < 9) begin opcode = ops[$urandom_range(0, 9)]; funct = 6'($urandom); end
      else            begin opcode = 6'($urandom); funct = 6'($urandom); end
      shamt  = 5'($urandom);
      imm    = 16'($urandom);
      rs_val = $urandom;
      rt_val = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      dst    = 5'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
